// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - data-memory arbiter state encoding and byte-enable legality
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    PAUSE = 2'd2
  } arb_state_e;

  localparam logic PICK_CPU = 1'b0;
  localparam logic PICK_DMA = 1'b1;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_BYTE1   = 4'b0010;
  localparam logic [3:0] BE_BYTE2   = 4'b0100;
  localparam logic [3:0] BE_BYTE3   = 4'b1000;

  // Only naturally aligned word, halfword and byte lanes reach the memory.
  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_WORD, BE_HALF_LO, BE_HALF_HI,
      BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: be_legal = 1'b1;
      default:                                be_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// rtl/dm_arb_rr.sv - two-requester round-robin picker (req0 = CPU, req1 = DMA)
module dm_arb_rr
  import dm_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic pick
);

  logic prio;

  always_comb begin
    pick = PICK_CPU;
    if (req0 && req1) begin
      pick = prio;
    end else if (req1) begin
      pick = PICK_DMA;
    end
  end

  // After a decision the other requester is favoured next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PICK_CPU;
    end else if (advance) begin
      prio <= ~pick;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - data-memory arbiter between CPU M stage and DMA bursts
// Optional statistics counters are enabled by defining DM_ARB_STATS_EN.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int LEN_W      = 4,
  parameter int CPU_STARVE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic [31:0]       cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic [31:0]       dma_wdata,
  input  logic [3:0]        dma_be,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic              dma_done,
  output logic              be_err,
  output logic              dm_we,
  output logic [31:0]       dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
`ifdef DM_ARB_STATS_EN
  output logic [31:0]       stat_cpu_gnt,
  output logic [31:0]       stat_dma_beats,
  output logic [15:0]       stat_stall,
`endif
  input  logic [31:0]       dm_rdata
);

  localparam int ST_W = $clog2(CPU_STARVE + 1);

  arb_state_e       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic [ST_W-1:0]  starve_q, starve_d, starve_inc;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic             dma_req_eff;
  logic             rr_adv;
  logic             pick;

  // The requester still holds dma_req during its done pulse; that is not a new burst.
  assign dma_req_eff = dma_req && !done_q;

  dm_arb_rr u_rr (
    .clk     (clk),
    .reset   (reset),
    .req0    (cpu_req),
    .req1    (dma_req_eff),
    .advance (rr_adv),
    .pick    (pick)
  );

  assign starve_inc = (starve_q == ST_W'(CPU_STARVE)) ? starve_q : starve_q + ST_W'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    done_d  = 1'b0;
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    rr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || dma_req_eff) begin
          rr_adv = 1'b1;
          if (pick == PICK_CPU) begin
            cpu_gnt = 1'b1;
          end else begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            cnt_d   = (dma_len == '0) ? LEN_W'(1) : dma_len;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        dma_gnt = 1'b1;
        addr_d  = {addr_q[31:12], addr_q[11:2] + 10'd1, addr_q[1:0]};
        cnt_d   = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cpu_req && starve_inc == ST_W'(CPU_STARVE)) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        cpu_gnt = cpu_req;
        state_d = BURST;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt) begin
      starve_d = '0;
    end else if (cpu_req) begin
      starve_d = starve_inc;
    end
  end

  // Memory-side mux; an illegal write lane pattern is dropped but still consumes the grant.
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_be    = '0;
    be_err   = 1'b0;
    if (cpu_gnt) begin
      dm_addr  = cpu_addr;
      dm_wdata = cpu_wdata;
      dm_be    = cpu_be;
      if (cpu_we) begin
        if (be_legal(cpu_be)) begin
          dm_we = 1'b1;
        end else begin
          be_err = 1'b1;
          dm_be  = '0;
        end
      end
    end else if (dma_gnt) begin
      dm_addr  = addr_q;
      dm_wdata = dma_wdata;
      dm_be    = dma_be;
      if (we_q) begin
        if (be_legal(dma_be)) begin
          dm_we = 1'b1;
        end else begin
          be_err = 1'b1;
          dm_be  = '0;
        end
      end
    end
  end

  assign cpu_rdata  = cpu_gnt ? dm_rdata : '0;
  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;
  assign dma_done   = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      starve_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      done_q   <= done_d;
      starve_q <= starve_d;
      rvalid_q <= dma_gnt && !we_q;
      if (dma_gnt && !we_q) begin
        rdata_q <= dm_rdata;
      end
    end
  end

`ifdef DM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_gnt   <= '0;
      stat_dma_beats <= '0;
      stat_stall     <= '0;
    end else begin
      if (cpu_gnt) begin
        stat_cpu_gnt <= stat_cpu_gnt + 32'd1;
      end
      if (dma_gnt) begin
        stat_dma_beats <= stat_dma_beats + 32'd1;
      end
      if (cpu_req && !cpu_gnt && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed self-checking bench for dm_arbiter
module tb_dm_arbiter;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr, cpu_wdata;
  logic [3:0]       cpu_be;
  logic             cpu_gnt;
  logic [31:0]      cpu_rdata;
  logic             dma_req, dma_we;
  logic [31:0]      dma_addr;
  logic [LEN_W-1:0] dma_len;
  logic [31:0]      dma_wdata;
  logic [3:0]       dma_be;
  logic             dma_gnt, dma_rvalid, dma_done, be_err;
  logic [31:0]      dma_rdata;
  logic             dm_we;
  logic [31:0]      dm_addr, dm_wdata, dm_rdata;
  logic [3:0]       dm_be;

  logic             pl_en;
  logic [9:0]       pl_idx;
  logic [31:0]      pl_data;
  logic [31:0]      mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.LEN_W(LEN_W), .CPU_STARVE(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_be(dma_be), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .dma_done(dma_done), .be_err(be_err),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata)
  );

  // Single-port data memory with combinational read and a bench preload port.
  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (dm_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dm_be[b]) mem[dm_addr[11:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_len = 0; dma_wdata = 0; dma_be = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pl_en = 1; pl_idx = idx[9:0]; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  function automatic logic [137:0] all_outs();
    return {cpu_gnt, dma_gnt, dma_rvalid, dma_done, be_err, dm_we, dm_be,
            dm_addr, dm_wdata, cpu_rdata, dma_rdata};
  endfunction

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    cpu_req = 1; dma_req = 1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    tick();
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_be = 4'hF; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, dm_we, dm_addr} !== {1'b1, 1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL cpu_write: got gnt=%b we=%b addr=%h expected gnt=1 we=1 addr=00000010",
               cpu_gnt, dm_we, dm_addr);
    end
    tick();
    cpu_we = 0; cpu_wdata = 0;
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cpu_readback: got %h expected deadbeef", cpu_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_dma_read_burst();
    logic [31:0] aexp [3];
    logic [31:0] dexp [3];
    int ngnt = 0, nval = 0, ndone = 0, first_gnt = -1, first_val = -1;
    logic saw_done = 0;
    aexp = '{32'hFF8, 32'hFFC, 32'h000};
    dexp = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    preload(1022, 32'hA5A50001);
    preload(1023, 32'hA5A50002);
    preload(0, 32'hA5A50003);
    dma_req = 1; dma_we = 0; dma_addr = 32'hFF8; dma_len = 3;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dma_gnt) begin
        if (first_gnt < 0) first_gnt = c;
        if (ngnt < 3) begin
          n_checks++;
          if (dm_addr !== aexp[ngnt]) begin
            n_fail++;
            $display("FAIL burst_addr%0d: got %h expected %h", ngnt, dm_addr, aexp[ngnt]);
          end
        end
        ngnt++;
      end
      if (dma_rvalid) begin
        if (first_val < 0) first_val = c;
        if (nval < 3) begin
          n_checks++;
          if (dma_rdata !== dexp[nval]) begin
            n_fail++;
            $display("FAIL burst_rdata%0d: got %h expected %h", nval, dma_rdata, dexp[nval]);
          end
        end
        nval++;
      end
      if (dma_done) begin
        ndone++;
        saw_done = 1;
      end
      tick();
      if (saw_done) dma_req = 0;
    end
    n_checks++;
    if ({ngnt, nval, ndone} !== {32'd3, 32'd3, 32'd1}) begin
      n_fail++;
      $display("FAIL burst_counts: got gnt=%0d rvalid=%0d done=%0d expected 3 3 1", ngnt, nval, ndone);
    end
    n_checks++;
    if (first_val !== first_gnt + 1) begin
      n_fail++;
      $display("FAIL rvalid_lag: got first rvalid cycle %0d expected %0d", first_val, first_gnt + 1);
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_g [8];
    exp_g = '{3'b100, 3'b000, 3'b010, 3'b010, 3'b101, 3'b000, 3'b010, 3'b101};
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h100; dma_len = 2;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({cpu_gnt, dma_gnt, dma_done} !== exp_g[c]) begin
        n_fail++;
        $display("FAIL simul_cycle%0d: got cpu/dma/done=%b expected %b",
                 c, {cpu_gnt, dma_gnt, dma_done}, exp_g[c]);
      end
      tick();
      if (c == 4) begin
        dma_addr = 32'h104; dma_len = 1;
      end
      if (c == 7) dma_req = 0;
    end
    idle_inputs();
  endtask

  task automatic test_starve();
    int nbeats = 0, ncpu = 0, gnt_cycle = -1, done_cycle = -1, addr_bad = 0, overlap = 0;
    do_reset();
    dma_req = 1; dma_we = 0; dma_addr = 32'h200; dma_len = 4'hF;
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    for (int c = 1; c < 30; c++) begin
      logic got_cpu;
      @(negedge clk);
      got_cpu = cpu_gnt;
      if (cpu_gnt && dma_gnt) overlap++;
      if (dma_gnt) begin
        if (dm_addr !== 32'h200 + 32'(4 * nbeats)) addr_bad++;
        nbeats++;
      end
      if (cpu_gnt) begin
        ncpu++;
        gnt_cycle = c;
      end
      if (dma_done) done_cycle = c;
      tick();
      if (got_cpu) cpu_req = 0;
      if (done_cycle >= 0) break;
    end
    n_checks++;
    if (nbeats !== 15) begin
      n_fail++;
      $display("FAIL starve_beats: got %0d expected 15", nbeats);
    end
    n_checks++;
    if ({ncpu, gnt_cycle} !== {32'd1, 32'd9}) begin
      n_fail++;
      $display("FAIL starve_cpu_gnt: got count=%0d cycle=%0d expected count=1 cycle=9", ncpu, gnt_cycle);
    end
    n_checks++;
    if ({addr_bad, overlap} !== 64'd0) begin
      n_fail++;
      $display("FAIL starve_addr: got bad_addr=%0d overlap=%0d expected 0 0", addr_bad, overlap);
    end
    n_checks++;
    if (done_cycle !== 17) begin
      n_fail++;
      $display("FAIL starve_done: got cycle %0d expected 17", done_cycle);
    end
    idle_inputs();
  endtask

  task automatic test_be_err();
    preload(8, 32'h0BADF00D);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_be = 4'b0101; cpu_wdata = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if ({cpu_gnt, dm_we, be_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL be_err_cpu: got gnt/we/err=%b expected 101", {cpu_gnt, dm_we, be_err});
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (be_err !== 1'b0) begin
      n_fail++;
      $display("FAIL be_err_pulse: got %b expected 0", be_err);
    end
    n_checks++;
    if (mem[4] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL be_err_mem: got %h expected deadbeef", mem[4]);
    end
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_len = 0; dma_be = 4'b0110; dma_wdata = 32'h55555555;
    tick();
    @(negedge clk);
    n_checks++;
    if ({dma_gnt, dm_we, be_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL be_err_dma: got gnt/we/err=%b expected 101", {dma_gnt, dm_we, be_err});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({dma_done, dma_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL be_err_dma_done: got done/gnt=%b expected 10", {dma_done, dma_gnt});
    end
    tick();
    idle_inputs();
    n_checks++;
    if (mem[8] !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL be_err_dma_mem: got %h expected 0badf00d", mem[8]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int ndone = 0, ngnt = 0;
    do_reset();
    dma_req = 1; dma_we = 0; dma_addr = 32'h300; dma_len = 5;
    tick();
    tick();
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (all_outs() !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h expected 0", all_outs());
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      if (dma_done) ndone++;
      if (dma_gnt || dma_rvalid) ngnt++;
    end
    n_checks++;
    if ({ndone, ngnt} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: got done=%0d dma_activity=%0d expected 0 0", ndone, ngnt);
    end
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    n_checks++;
    if (cpu_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got cpu_gnt=%b expected 1", cpu_gnt);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    pl_en = 0; pl_idx = 0; pl_data = 0;
    test_reset();
    test_cpu_write();
    test_dma_read_burst();
    test_simultaneous();
    test_starve();
    test_be_err();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
